// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - EX operand forwarding, load-use/scoreboard stall control and status
module forwarding_hazard_unit #(
    parameter int RegAddrWidth = 5,
    parameter int NumSrc       = 2,
    parameter int MemLoadFwd   = 1,
    parameter int StallTimeout = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           id_valid,
    input  logic [NumSrc*RegAddrWidth-1:0] id_rs,
    input  logic [NumSrc-1:0]              id_rs_used,
    input  logic [RegAddrWidth-1:0]        id_rd,
    input  logic                           id_we,
    input  logic [NumSrc*RegAddrWidth-1:0] ex_rs,
    input  logic [RegAddrWidth-1:0]        ex_rd,
    input  logic                           ex_we,
    input  logic                           ex_mem_read,
    input  logic [RegAddrWidth-1:0]        mem_rd,
    input  logic                           mem_we,
    input  logic                           mem_read,
    input  logic [RegAddrWidth-1:0]        wb_rd,
    input  logic                           wb_we,
    input  logic                           lu_issue,
    input  logic [RegAddrWidth-1:0]        lu_rd,
    input  logic                           lu_done,
    input  logic [RegAddrWidth-1:0]        lu_done_rd,
    output logic [NumSrc*3-1:0]            fwd_sel,
    output logic                           stall_id,
    output logic                           flush_ex,
    output logic [15:0]                    stall_count,
    output logic                           sb_error,
    output logic                           timeout
);

    localparam int          NumRegs      = 2 ** RegAddrWidth;
    localparam bit          LoadBypass   = (MemLoadFwd != 0);
    localparam logic [15:0] TimeoutLimit = 16'(StallTimeout);

    logic [NumRegs-1:1] pending_q;
    logic [NumRegs-1:0] pending;
    logic [NumRegs-1:0] pending_next;
    logic               load_use_hazard;
    logic               sb_hazard;
    logic               issue_error;
    logic               done_error;
    logic [15:0]        to_cnt;
    logic [15:0]        to_cnt_inc;

    // x0 is never pending; keep it out of the register entirely
    assign pending = {pending_q, 1'b0};

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (ex_rs[i*RegAddrWidth +: RegAddrWidth] != '0) begin
                if (mem_we && mem_rd == ex_rs[i*RegAddrWidth +: RegAddrWidth]) begin
                    if (!mem_read) begin
                        fwd_sel[i*3 +: 3] = 3'b001;
                    end else if (LoadBypass) begin
                        fwd_sel[i*3 +: 3] = 3'b010;
                    end
                end else if (wb_we && wb_rd == ex_rs[i*RegAddrWidth +: RegAddrWidth]) begin
                    fwd_sel[i*3 +: 3] = 3'b100;
                end
            end
        end
    end

    always_comb begin
        load_use_hazard = 1'b0;
        sb_hazard       = 1'b0;
        for (int i = 0; i < NumSrc; i++) begin
            if (id_valid && id_rs_used[i]) begin
                if (id_rs[i*RegAddrWidth +: RegAddrWidth] != '0) begin
                    if (ex_we && ex_mem_read && ex_rd == id_rs[i*RegAddrWidth +: RegAddrWidth]) begin
                        load_use_hazard = 1'b1;
                    end
                    if (!LoadBypass && mem_we && mem_read &&
                        mem_rd == id_rs[i*RegAddrWidth +: RegAddrWidth]) begin
                        load_use_hazard = 1'b1;
                    end
                end
                if (pending[id_rs[i*RegAddrWidth +: RegAddrWidth]]) begin
                    sb_hazard = 1'b1;
                end
            end
        end
        if (id_valid && id_we && pending[id_rd]) begin
            sb_hazard = 1'b1;
        end
    end

    assign stall_id = load_use_hazard | sb_hazard;
    assign flush_ex = stall_id;

    // Clear before set so a done and re-issue to the same register keeps it busy
    always_comb begin
        pending_next = pending;
        if (lu_done) begin
            pending_next[lu_done_rd] = 1'b0;
        end
        if (lu_issue) begin
            pending_next[lu_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    assign issue_error = lu_issue && pending[lu_rd] && !(lu_done && lu_done_rd == lu_rd);
    assign done_error  = lu_done && !pending[lu_done_rd];
    assign to_cnt_inc  = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q   <= '0;
            stall_count <= '0;
            sb_error    <= 1'b0;
            timeout     <= 1'b0;
            to_cnt      <= '0;
        end else begin
            pending_q <= pending_next[NumRegs-1:1];
            if (stall_id && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
            if (issue_error || done_error) begin
                sb_error <= 1'b1;
            end
            if (sb_hazard) begin
                to_cnt <= to_cnt_inc;
                if (to_cnt_inc >= TimeoutLimit) begin
                    timeout <= 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb/tb_forwarding_hazard_unit.sv - bench for forwarding_hazard_unit with load bypass on and off
module tb_forwarding_hazard_unit;

    localparam int RW = 5;
    localparam int NS = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 1'b0;
    logic [NS*RW-1:0] id_rs = '0;
    logic [NS-1:0] id_rs_used = '0;
    logic [RW-1:0] id_rd = '0;
    logic          id_we = 1'b0;
    logic [NS*RW-1:0] ex_rs = '0;
    logic [RW-1:0] ex_rd = '0;
    logic          ex_we = 1'b0;
    logic          ex_mem_read = 1'b0;
    logic [RW-1:0] mem_rd = '0;
    logic          mem_we = 1'b0;
    logic          mem_read = 1'b0;
    logic [RW-1:0] wb_rd = '0;
    logic          wb_we = 1'b0;
    logic          lu_issue = 1'b0;
    logic [RW-1:0] lu_rd = '0;
    logic          lu_done = 1'b0;
    logic [RW-1:0] lu_done_rd = '0;

    logic [NS*3-1:0] fwd_a, fwd_b;
    logic            stall_a, stall_b, flush_a, flush_b;
    logic [15:0]     cnt_a, cnt_b;
    logic            err_a, err_b, to_a, to_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit #(.RegAddrWidth(RW), .NumSrc(NS), .MemLoadFwd(1), .StallTimeout(TO)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_we(id_we), .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_we(mem_we), .mem_read(mem_read),
        .wb_rd(wb_rd), .wb_we(wb_we), .lu_issue(lu_issue), .lu_rd(lu_rd), .lu_done(lu_done),
        .lu_done_rd(lu_done_rd), .fwd_sel(fwd_a), .stall_id(stall_a), .flush_ex(flush_a),
        .stall_count(cnt_a), .sb_error(err_a), .timeout(to_a)
    );

    forwarding_hazard_unit #(.RegAddrWidth(RW), .NumSrc(NS), .MemLoadFwd(0), .StallTimeout(TO)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_we(id_we), .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_we(mem_we), .mem_read(mem_read),
        .wb_rd(wb_rd), .wb_we(wb_we), .lu_issue(lu_issue), .lu_rd(lu_rd), .lu_done(lu_done),
        .lu_done_rd(lu_done_rd), .fwd_sel(fwd_b), .stall_id(stall_b), .flush_ex(flush_b),
        .stall_count(cnt_b), .sb_error(err_b), .timeout(to_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a set of busy registers plus per-instance counters
    bit          pend [32];
    logic [31:0] m_cnt [2];
    bit          m_err = 1'b0;
    bit          m_to = 1'b0;
    int          m_run = 0;

    initial begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    end

    function automatic logic [2:0] m_fwd(input bit mlf, input int i);
        logic [RW-1:0] s;
        s = ex_rs[i*RW +: RW];
        if (s == 0) return 3'b000;
        if (mem_we && mem_rd == s) return mem_read ? (mlf ? 3'b010 : 3'b000) : 3'b001;
        if (wb_we && wb_rd == s) return 3'b100;
        return 3'b000;
    endfunction

    function automatic bit m_lu(input bit mlf);
        logic [RW-1:0] r;
        for (int i = 0; i < NS; i++) begin
            r = id_rs[i*RW +: RW];
            if (id_valid && id_rs_used[i] && r != 0) begin
                if (ex_we && ex_mem_read && ex_rd == r) return 1'b1;
                if (!mlf && mem_we && mem_read && mem_rd == r) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit m_sb();
        if (!id_valid) return 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (id_rs_used[i] && pend[id_rs[i*RW +: RW]]) return 1'b1;
        end
        return id_we && pend[id_rd];
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit sbh;
        if (reset) begin
            for (int i = 0; i < 32; i++) pend[i] <= 1'b0;
            m_cnt[0] <= 0;
            m_cnt[1] <= 0;
            m_err    <= 1'b0;
            m_to     <= 1'b0;
            m_run    <= 0;
        end else begin
            sbh = m_sb();
            for (int d = 0; d < 2; d++) begin
                if ((m_lu(d == 0) || sbh) && m_cnt[d] < 65535) m_cnt[d] <= m_cnt[d] + 1;
            end
            if (lu_issue && pend[lu_rd] && !(lu_done && lu_done_rd == lu_rd)) m_err <= 1'b1;
            if (lu_done && !pend[lu_done_rd]) m_err <= 1'b1;
            if (sbh) begin
                m_run <= m_run + 1;
                if (m_run + 1 >= TO) m_to <= 1'b1;
            end else begin
                m_run <= 0;
            end
            if (lu_done) pend[lu_done_rd] <= 1'b0;
            if (lu_issue && lu_rd != 0) pend[lu_rd] <= 1'b1;
        end
    end

    task automatic cmp_dut(input string tag, input bit mlf, input logic [NS*3-1:0] fwd,
                           input logic st, input logic fl, input logic [15:0] cnt,
                           input logic er, input logic tmo, input logic [31:0] ecnt);
        bit est;
        est = m_lu(mlf) || m_sb();
        for (int i = 0; i < NS; i++) chk({tag, "_fwd"}, 32'(fwd[i*3 +: 3]), 32'(m_fwd(mlf, i)));
        chk({tag, "_stall"}, 32'(st), 32'(est));
        chk({tag, "_flush"}, 32'(fl), 32'(est));
        chk({tag, "_stall_count"}, 32'(cnt), ecnt);
        chk({tag, "_sb_error"}, 32'(er), 32'(m_err));
        chk({tag, "_timeout"}, 32'(tmo), 32'(m_to));
    endtask

    always @(negedge clk) begin
        cmp_dut("a", 1'b1, fwd_a, stall_a, flush_a, cnt_a, err_a, to_a, m_cnt[0]);
        cmp_dut("b", 1'b0, fwd_b, stall_b, flush_b, cnt_b, err_b, to_b, m_cnt[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_we = 0;
        ex_rs = '0; ex_rd = '0; ex_we = 0; ex_mem_read = 0;
        mem_rd = '0; mem_we = 0; mem_read = 0; wb_rd = '0; wb_we = 0;
        lu_issue = 0; lu_rd = '0; lu_done = 0; lu_done_rd = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    function automatic logic [RW-1:0] rr();
        return RW'($urandom_range(0, 7));
    endfunction

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_timeout", 32'(to_a), 32'd0);

        // MEM beats WB; x0 never forwards
        tick();
        ex_rs[4:0] = 5; mem_we = 1; mem_rd = 5; mem_read = 0; wb_we = 1; wb_rd = 5;
        @(negedge clk);
        chk("fwd_mem_over_wb_a", 32'(fwd_a[2:0]), 32'b001);
        chk("fwd_mem_over_wb_b", 32'(fwd_b[2:0]), 32'b001);
        tick();
        ex_rs[4:0] = 0;
        @(negedge clk);
        chk("fwd_x0", 32'(fwd_a[2:0]), 32'b000);

        // load-use on x7 via slot 1
        tick(); idle();
        ex_we = 1; ex_mem_read = 1; ex_rd = 7;
        id_valid = 1; id_rs[9:5] = 7; id_rs_used = 2'b10;
        @(negedge clk);
        chk("lu_cyc1_a", 32'(stall_a), 32'd1);
        chk("lu_cyc1_b", 32'(stall_b), 32'd1);
        tick();
        ex_we = 0; ex_mem_read = 0; mem_we = 1; mem_read = 1; mem_rd = 7;
        @(negedge clk);
        chk("lu_cyc2_a", 32'(stall_a), 32'd0);
        chk("lu_cyc2_b", 32'(stall_b), 32'd1);
        tick();
        mem_we = 0; mem_read = 0; wb_we = 1; wb_rd = 7;
        @(negedge clk);
        chk("lu_cyc3_b", 32'(stall_b), 32'd0);
        tick();
        id_valid = 0; ex_rs[9:5] = 7; wb_we = 0; mem_we = 1; mem_read = 1; mem_rd = 7;
        @(negedge clk);
        chk("fwd_load_a", 32'(fwd_a[5:3]), 32'b010);
        chk("fwd_load_b", 32'(fwd_b[5:3]), 32'b000);
        tick();
        mem_we = 0; mem_read = 0; wb_we = 1; wb_rd = 7;
        @(negedge clk);
        chk("fwd_wb_b", 32'(fwd_b[5:3]), 32'b100);

        // scoreboard: issue x9, done at cycle 10
        do_reset();
        lu_issue = 1; lu_rd = 9;
        @(negedge clk);
        chk("sb_cyc0", 32'(stall_a), 32'd0);
        tick();
        lu_issue = 0; id_valid = 1; id_rs[4:0] = 9; id_rs_used = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) begin lu_done = 1; lu_done_rd = 9; end
            @(negedge clk);
            chk("sb_stall_hold", 32'(stall_a), 32'd1);
            if (k == 8) chk("sb_timeout_pre", 32'(to_a), 32'd0);
            if (k == 9) chk("sb_timeout_post", 32'(to_a), 32'd1);
            tick();
            lu_done = 0;
        end
        @(negedge clk);
        chk("sb_release", 32'(stall_a), 32'd0);
        chk("sb_count10", 32'(cnt_a), 32'd10);
        chk("sb_no_err", 32'(err_a), 32'd0);

        // same-cycle done and issue to x4, then stray done on x12
        do_reset();
        lu_issue = 1; lu_rd = 4;
        tick();
        lu_done = 1; lu_done_rd = 4;
        tick();
        lu_issue = 0; lu_done = 0; id_valid = 1; id_rs[4:0] = 4; id_rs_used = 2'b01;
        @(negedge clk);
        chk("same_cyc_pending", 32'(stall_a), 32'd1);
        chk("same_cyc_err", 32'(err_a), 32'd0);
        tick();
        id_valid = 0; lu_done = 1; lu_done_rd = 12;
        tick();
        lu_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_done_err", 32'(err_a), 32'd1);
            tick();
        end

        // stuck scoreboard stall, then async reset mid-cycle
        do_reset();
        lu_issue = 1; lu_rd = 3;
        tick();
        lu_issue = 0; id_valid = 1; id_rs[4:0] = 3; id_rs_used = 2'b01;
        for (int k = 0; k < 9; k++) tick();
        @(negedge clk);
        chk("stuck_timeout", 32'(to_a), 32'd1);
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("async_stall", 32'(stall_a), 32'd0);
        chk("async_timeout", 32'(to_a), 32'd0);
        chk("async_count", 32'(cnt_a), 32'd0);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("async_pending_clear", 32'(stall_a), 32'd0);

        // randomized traffic on a small register window
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset = (n % 400 == 399);
            id_valid = ($urandom % 4) != 0;
            for (int i = 0; i < NS; i++) begin
                id_rs[i*RW +: RW] = rr();
                ex_rs[i*RW +: RW] = rr();
            end
            id_rs_used = NS'($urandom);
            id_rd = rr(); id_we = $urandom % 2;
            ex_rd = rr(); ex_we = $urandom % 2; ex_mem_read = ($urandom % 3) == 0;
            mem_rd = rr(); mem_we = $urandom % 2; mem_read = ($urandom % 3) == 0;
            wb_rd = rr(); wb_we = $urandom % 2;
            lu_issue = ($urandom % 5) == 0; lu_rd = rr();
            lu_done = ($urandom % 5) == 0; lu_done_rd = rr();
        end
        tick();
        idle();
        reset = 0;
        @(negedge clk);
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
